// File: rtl/candbank_pkg.sv
// Shared sizing and FSM state encoding for the candidate bank controller.
package candbank_pkg;
  localparam int DEPTH_WORDS = 16;
  localparam int WORD_WIDTH  = 16;
  localparam int CNT_W       = $clog2(DEPTH_WORDS + 1);
  localparam int PTR_W       = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    SCAN,
    DONE
  } state_t;
endpackage

// File: rtl/candbank_max_unit.sv
// Running-maximum tracker: the best_* outputs already include this cycle's candidate.
module candbank_max_unit
  import candbank_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] value,
  input  logic [PTR_W-1:0]      index,
  output logic [WORD_WIDTH-1:0] best_val,
  output logic [PTR_W-1:0]      best_idx
);
  logic [WORD_WIDTH-1:0] best_q;
  logic [PTR_W-1:0]      idx_q;
  logic                  take;

  // Strict greater-than, so a tie keeps the earlier index.
  assign take     = load | (en & (value > best_q));
  assign best_val = take ? value : best_q;
  assign best_idx = take ? index : idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= '0;
      idx_q  <= '0;
    end else if (take) begin
      best_q <= value;
      idx_q  <= index;
    end
  end
endmodule

// File: rtl/candidate_bank_ctrl.sv
// Stores candidate words into an external byte bank and scans them for the maximum.
// state | meaning
// IDLE  | accept an insert or a scan request (round-robin on contention)
// WRITE | one-cycle bank write of the latched word at byte 2*count
// SCAN  | read word ptr, fold into the running max, one word per cycle
// DONE  | publish result, pulse scan_done
module candidate_bank_ctrl #(
  parameter int DEPTH_WORDS = candbank_pkg::DEPTH_WORDS,
  parameter int WORD_WIDTH  = candbank_pkg::WORD_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           ins_valid,
  output logic                           ins_ready,
  input  logic [WORD_WIDTH-1:0]          ins_data,
  input  logic                           scan_req,
  output logic                           scan_busy,
  output logic                           scan_done,
  output logic                           best_valid,
  output logic [candbank_pkg::PTR_W-1:0] best_idx,
  output logic [WORD_WIDTH-1:0]          best_val,
  output logic [candbank_pkg::CNT_W-1:0] count,
  output logic                           bank_wr_en,
  output logic [candbank_pkg::PTR_W:0]   bank_index,
  output logic [WORD_WIDTH-1:0]          bank_data_in,
  input  logic [WORD_WIDTH-1:0]          bank_data_out
);
  import candbank_pkg::*;

  state_t                state;
  logic [PTR_W-1:0]      ptr;
  logic [WORD_WIDTH-1:0] data_q;
  logic                  rr_pref_ins;
  logic                  full;
  logic                  last_ptr;
  logic                  scan_grant;
  logic                  ins_grant;
  logic                  unit_load;
  logic                  unit_en;
  logic [WORD_WIDTH-1:0] unit_val;
  logic [PTR_W-1:0]      unit_idx;

  assign full      = (count == CNT_W'(DEPTH_WORDS));
  assign last_ptr  = ((CNT_W'(ptr) + CNT_W'(1)) == count);
  assign unit_en   = (state == SCAN);
  assign unit_load = (state == SCAN) && (ptr == '0);

  always_comb begin
    scan_grant   = (state == IDLE) && scan_req && !clear &&
                   (!ins_valid || full || !rr_pref_ins);
    ins_grant    = (state == IDLE) && ins_valid && !full && !clear && !scan_grant;
    ins_ready    = (state == IDLE) && !full && !clear && !scan_grant;
    bank_wr_en   = (state == WRITE) && !clear;
    bank_index   = '0;
    bank_data_in = '0;
    if (state == WRITE) begin
      bank_index   = {count[PTR_W-1:0], 1'b0};
      bank_data_in = data_q;
    end else if (state == SCAN) begin
      bank_index = {ptr, 1'b0};
    end
  end

  candbank_max_unit u_max (
    .clk      (clk),
    .rst      (rst),
    .load     (unit_load),
    .en       (unit_en),
    .value    (bank_data_out),
    .index    (ptr),
    .best_val (unit_val),
    .best_idx (unit_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      ptr         <= '0;
      data_q      <= '0;
      rr_pref_ins <= 1'b1;
      scan_busy   <= 1'b0;
      scan_done   <= 1'b0;
      best_valid  <= 1'b0;
      best_idx    <= '0;
      best_val    <= '0;
    end else if (clear) begin
      state      <= IDLE;
      count      <= '0;
      ptr        <= '0;
      scan_busy  <= 1'b0;
      scan_done  <= 1'b0;
      best_valid <= 1'b0;
      best_idx   <= '0;
      best_val   <= '0;
    end else begin
      case (state)
        IDLE: begin
          scan_done <= 1'b0;
          if (scan_grant) begin
            rr_pref_ins <= 1'b1;
            ptr         <= '0;
            scan_busy   <= 1'b1;
            if (count == '0) begin
              // Empty bank: report an invalid, zeroed result straight away.
              state      <= DONE;
              scan_done  <= 1'b1;
              best_valid <= 1'b0;
              best_idx   <= '0;
              best_val   <= '0;
            end else begin
              state <= SCAN;
            end
          end else if (ins_grant) begin
            rr_pref_ins <= 1'b0;
            data_q      <= ins_data;
            state       <= WRITE;
          end
        end
        WRITE: begin
          count <= count + 1'b1;
          state <= IDLE;
        end
        SCAN: begin
          ptr <= ptr + 1'b1;
          if (last_ptr) begin
            state      <= DONE;
            scan_done  <= 1'b1;
            best_valid <= 1'b1;
            best_idx   <= unit_idx;
            best_val   <= unit_val;
          end
        end
        DONE: begin
          scan_done <= 1'b0;
          scan_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/candidate_bank_ctrl.md
CANDIDATE_BANK_CTRL -- requirements
Module: candidate_bank_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, 16: number of 16-bit candidate words held in the attached byte bank.
REQ-002 Parameter WORD_WIDTH, 16: candidate word width in bits.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 clear  in  1  discard all stored candidates and abort any scan.
REQ-007 ins_valid  in  1, ins_ready  out  1, ins_data  in  16: candidate insert handshake.
REQ-008 scan_req  in  1  level request to find the maximum stored candidate.
REQ-009 scan_busy  out  1, scan_done  out  1 (one-cycle pulse), best_valid  out  1.
REQ-010 best_idx  out  4, best_val  out  16  result of the last completed scan.
REQ-011 count  out  5  number of stored candidates, 0..16.
REQ-012 bank_wr_en  out  1, bank_index  out  5, bank_data_in  out  16, bank_data_out  in  16: port to the byte bank. The bank stores word w at bytes 2w and 2w+1, high byte first. It writes on the clock edge and reads combinationally.

Function
REQ-013 FSM states SHALL be IDLE, WRITE, SCAN and DONE.
REQ-014 ins_ready SHALL be 1 only in IDLE with count<16, clear=0, and no granted scan that cycle.
REQ-015 Insert handshake (ins_valid&ins_ready): register ins_data and go to WRITE. In WRITE, drive bank_wr_en=1, bank_index=2*count and bank_data_in=latched data for exactly one cycle. Then increment count and return to IDLE. This gives a 2-cycle insert throughput.
REQ-016 At count=16, ins_ready SHALL stay 0. A pending ins_valid is held off, not dropped, and the bank is not written.
REQ-017 scan_req in IDLE with count>0 SHALL enter SCAN with ptr=0. Each SCAN cycle drives bank_index=2*ptr and compares bank_data_out with the running best; ptr advances by 1 per cycle.
REQ-018 Comparison SHALL be unsigned strict greater-than. The word at ptr=0 is loaded unconditionally. Ties keep the lowest index.
REQ-019 After ptr=count-1 is evaluated, the FSM SHALL enter DONE. DONE pulses scan_done for one cycle, updates best_idx and best_val, sets best_valid=1, then returns to IDLE.
REQ-020 Latency: scan_req sampled in cycle t gives scan_done in cycle t+count+1. scan_busy SHALL be 1 in SCAN and DONE.
REQ-021 scan_req with count=0 SHALL go directly to DONE and pulse scan_done, with best_valid=0, best_idx=0 and best_val=0.
REQ-022 When ins_valid and scan_req both arrive in IDLE, the block SHALL grant the requester not granted last. The round-robin bit updates on every grant.
REQ-023 Outside WRITE, bank_wr_en SHALL be 0. Outside SCAN and WRITE, bank_index SHALL be 0.
REQ-024 best_idx, best_val and best_valid SHALL hold between scans. An insert does not invalidate them.
REQ-025 clear SHALL have priority in any state. Next cycle: IDLE, count=0, best_valid=0, best_idx=0, best_val=0, no scan_done pulse.
REQ-026 clear asserted in the WRITE cycle SHALL force bank_wr_en=0 that cycle. Bank contents are otherwise never erased; count alone defines validity.

Reset
REQ-027 rst SHALL take priority over clear. On the next edge it sets: state IDLE, count 0, ptr 0, latched data 0, round-robin bit preferring insert, all outputs 0.
REQ-028 rst asserted mid-WRITE or mid-SCAN SHALL suppress bank_wr_en and scan_done from the following cycle.

Structure
REQ-029 Package candbank_pkg SHALL hold DEPTH_WORDS, WORD_WIDTH, the count and pointer widths, and the FSM state enum.
REQ-030 The running-max compare-and-update SHALL be sub-module candbank_max_unit (inputs: load, en, value, index; outputs: best value, best index). The bank is instantiated outside this block.

Verification
REQ-031 Insert 0x0010, 0x00F0, 0x0080, then scan -> bank bytes 0..5 = 00 10 00 F0 00 80; scan_done 4 cycles after scan_req; best_idx=1, best_val=0x00F0.
REQ-032 Insert 16 words, hold ins_valid with 0xFFFF -> ins_ready=0, count=16, bank_wr_en never asserts for the 17th word.
REQ-033 Insert 0x0500 at index 0 and 0x0500 at index 3, others 0x0100 -> best_idx=0 (tie keeps lowest).
REQ-034 Assert ins_valid and scan_req together twice in a row from IDLE -> first grant insert, second grant scan.
REQ-035 Scan with count=0 -> scan_done one cycle after req, best_valid=0. Then clear mid-SCAN with count=8 -> no scan_done, count=0 next cycle.
REQ-036 Assert rst during WRITE -> bank_wr_en=0 next cycle, all outputs 0, count=0.
